// File: rtl/fifo_drain_arbiter.sv
// Round-robin burst drain of NUM_PORTS source FIFOs into one merged stream,
// with credit-limited reads so the 4-entry output buffer can never overflow.
module fifo_drain_arbiter #(
    parameter int NUM_PORTS    = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter int MAX_BURST    = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            fifo_empty,
    output logic [NUM_PORTS-1:0]            fifo_read_enable,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_read_data,
    input  logic [NUM_PORTS-1:0]            fifo_read_data_valid,
    output logic [DATA_WIDTH-1:0]           output_data,
    output logic [$clog2(NUM_PORTS)-1:0]    output_port,
    output logic                            output_valid,
    input  logic                            output_ready,
    output logic                            grant_active,
    output logic [$clog2(NUM_PORTS)-1:0]    grant_port
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;
    localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);
    localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

    logic [0:0]              state;
    logic [PW-1:0]           last_grant;
    logic [7:0]              burst_count;
    logic [READ_LATENCY-1:0] pend_sr;
    logic [PW+DATA_WIDTH-1:0] buf_mem [4];
    logic [1:0]              wr_ptr;
    logic [1:0]              rd_ptr;
    logic [2:0]              occupancy;

    logic [2:0]              pending;
    logic                    credit;
    logic                    read_issue;
    logic [PW:0]             cand_sum;
    logic [PW-1:0]           cand;
    logic [PW-1:0]           next_port;
    logic                    found;
    logic                    push;
    logic                    pop;
    logic [PW-1:0]           push_port;
    logic [DATA_WIDTH-1:0]   push_data;
    logic                    push_found;

    // Reads still in flight count against the buffer, so a word always has a slot.
    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            pending = pending + 3'(pend_sr[i]);
        end
    end

    assign credit     = (4'(occupancy) + 4'(pending)) < 4'd4;
    assign read_issue = (state == S_BURST) && !reset && !fifo_empty[grant_port]
                        && credit && (burst_count < MAX_CNT);
    assign fifo_read_enable = read_issue ? (NUM_PORTS'(1) << grant_port) : '0;
    assign grant_active     = (state == S_BURST);

    // Round-robin search starting one past the last granted port, with wrap.
    always_comb begin
        next_port = last_grant;
        found     = 1'b0;
        cand_sum  = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            cand_sum = {1'b0, last_grant} + (PW+1)'(k + 1);
            if (cand_sum >= (PW+1)'(NUM_PORTS)) begin
                cand_sum = cand_sum - (PW+1)'(NUM_PORTS);
            end
            cand = cand_sum[PW-1:0];
            if (!found && !fifo_empty[cand]) begin
                found     = 1'b1;
                next_port = cand;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            last_grant  <= LAST_PORT;
            grant_port  <= '0;
            burst_count <= '0;
        end else if (state == S_IDLE) begin
            if (found && credit) begin
                state       <= S_BURST;
                grant_port  <= next_port;
                last_grant  <= next_port;
                burst_count <= '0;
            end
        end else begin
            if (read_issue) begin
                burst_count <= burst_count + 8'd1;
            end
            if (fifo_empty[grant_port] || burst_count == MAX_CNT) begin
                state <= S_IDLE;
            end
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        always_ff @(posedge clock) begin
            if (reset) pend_sr <= '0;
            else       pend_sr <= read_issue;
        end
    end else begin : g_latn
        always_ff @(posedge clock) begin
            if (reset) pend_sr <= '0;
            else       pend_sr <= {pend_sr[READ_LATENCY-2:0], read_issue};
        end
    end

    always_comb begin
        push_port  = '0;
        push_data  = '0;
        push_found = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!push_found && fifo_read_data_valid[i]) begin
                push_found = 1'b1;
                push_port  = PW'(i);
                push_data  = fifo_read_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign push = push_found && !reset;
    assign pop  = output_valid && output_ready;

    always_ff @(posedge clock) begin
        if (push) begin
            buf_mem[wr_ptr] <= {push_port, push_data};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 3'd1;
                2'b01:   occupancy <= occupancy - 3'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Head is masked while empty so stale entries never show after reset.
    assign output_valid = (occupancy != 3'd0);
    assign output_data  = output_valid ? buf_mem[rd_ptr][DATA_WIDTH-1:0] : '0;
    assign output_port  = output_valid ? buf_mem[rd_ptr][PW+DATA_WIDTH-1:DATA_WIDTH] : '0;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: instance 0 uses READ_LATENCY=1, instance 1 READ_LATENCY=2,
// both checked every cycle against a queue-based behavioural model plus directed literals.
module tb_fifo_drain_arbiter;
    localparam int MAX_B = 8;

    typedef struct { int p; logic [15:0] d; } ent_t;
    typedef struct { int due; int p; logic [15:0] d; } fly_t;

    logic        clock;
    logic        reset;
    logic        output_ready;
    logic [3:0]  f_empty [2];
    logic [3:0]  f_rd    [2];
    logic [63:0] f_data  [2];
    logic [3:0]  f_valid [2];
    logic [15:0] o_data  [2];
    logic [1:0]  o_port  [2];
    logic        o_valid [2];
    logic        ga      [2];
    logic [1:0]  gp      [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        fifo_drain_arbiter #(
            .NUM_PORTS(4), .DATA_WIDTH(16), .READ_LATENCY(g + 1), .MAX_BURST(MAX_B)
        ) u_dut (
            .clock(clock), .reset(reset),
            .fifo_empty(f_empty[g]), .fifo_read_enable(f_rd[g]),
            .fifo_read_data(f_data[g]), .fifo_read_data_valid(f_valid[g]),
            .output_data(o_data[g]), .output_port(o_port[g]), .output_valid(o_valid[g]),
            .output_ready(output_ready), .grant_active(ga[g]), .grant_port(gp[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic rst_req = 1'b1;
    logic rdy_req = 1'b1;

    logic [15:0] src_q [2][4][$];
    fly_t        infl  [2][$];
    ent_t        got   [2][$];
    int          b_port  [2][$];
    int          b_reads [2][$];
    int          rd_log  [$];
    bit          prev_ga [2];

    bit   m_busy [2];
    int   m_gp   [2];
    int   m_last [2];
    int   m_cnt  [2];
    int   m_hist [2][2];
    ent_t m_buf  [2][$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset(int g);
        m_busy[g] = 0; m_gp[g] = 0; m_last[g] = 3; m_cnt[g] = 0;
        m_hist[g][0] = 0; m_hist[g][1] = 0;
        m_buf[g].delete();
    endtask

    task automatic sample();
        @(negedge clock);
        for (int g = 0; g < 2; g++) begin
            int lat, pend, k, p;
            bit credit, ev, fnd;
            logic [3:0] exp_rd;
            ent_t e;
            fly_t f;
            lat    = g + 1;
            pend   = m_hist[g][0] + ((lat == 2) ? m_hist[g][1] : 0);
            credit = (m_buf[g].size() + pend) < 4;
            ev     = m_buf[g].size() != 0;
            exp_rd = '0;
            if (!reset && m_busy[g] && !f_empty[g][m_gp[g]] && credit && m_cnt[g] < MAX_B)
                exp_rd[m_gp[g]] = 1'b1;
            check("read_enable", f_rd[g], exp_rd);
            check("grant_active", ga[g], m_busy[g]);
            check("grant_port", gp[g], m_gp[g]);
            check("output_valid", o_valid[g], ev);
            if (ev) begin
                check("output_data", o_data[g], m_buf[g][0].d);
                check("output_port", o_port[g], m_buf[g][0].p);
            end

            if (o_valid[g] === 1'b1 && output_ready) begin
                e.p = int'(o_port[g]); e.d = o_data[g];
                got[g].push_back(e);
            end
            if (ga[g] === 1'b1 && !prev_ga[g]) begin
                b_port[g].push_back(int'(gp[g]));
                b_reads[g].push_back(0);
            end
            prev_ga[g] = (ga[g] === 1'b1);
            if (f_rd[g] != 4'd0 && b_reads[g].size() != 0)
                b_reads[g][b_reads[g].size() - 1]++;
            if (g == 0 && f_rd[0][2] === 1'b1) rd_log.push_back(cyc);

            // Source FIFOs respond to the strobes the DUT actually drives.
            for (int q = 0; q < 4; q++) begin
                if (f_rd[g][q] === 1'b1 && src_q[g][q].size() != 0) begin
                    f.due = cyc + lat; f.p = q; f.d = src_q[g][q].pop_front();
                    infl[g].push_back(f);
                end
            end

            if (reset) begin
                model_reset(g);
            end else begin
                if (ev && output_ready) void'(m_buf[g].pop_front());
                for (int q = 0; q < 4; q++) begin
                    if (f_valid[g][q]) begin
                        e.p = q; e.d = f_data[g][q*16 +: 16];
                        m_buf[g].push_back(e);
                        check("buffer_bound", m_buf[g].size() <= 4, 1);
                    end
                end
                m_hist[g][1] = m_hist[g][0];
                m_hist[g][0] = (exp_rd != 4'd0) ? 1 : 0;
                if (m_busy[g]) begin
                    if (f_empty[g][m_gp[g]] || m_cnt[g] == MAX_B) m_busy[g] = 0;
                    if (exp_rd != 4'd0) m_cnt[g]++;
                end else if (f_empty[g] != 4'hF && credit) begin
                    fnd = 0;
                    for (k = 1; k <= 4; k++) begin
                        p = (m_last[g] + k) % 4;
                        if (!fnd && !f_empty[g][p]) begin
                            fnd = 1; m_gp[g] = p; m_last[g] = p;
                        end
                    end
                    m_cnt[g] = 0; m_busy[g] = 1;
                end
            end
        end
    endtask

    task automatic advance();
        fly_t f;
        @(posedge clock);
        cyc++;
        #1;
        reset = rst_req;
        output_ready = rdy_req;
        for (int g = 0; g < 2; g++) begin
            f_valid[g] = '0;
            f_data[g]  = {4{16'hBAD0}};
            for (int p = 0; p < 4; p++) f_empty[g][p] = (src_q[g][p].size() == 0);
            if (infl[g].size() != 0 && infl[g][0].due == cyc) begin
                f = infl[g].pop_front();
                f_valid[g][f.p] = 1'b1;
                f_data[g][f.p*16 +: 16] = f.d;
            end
        end
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic clear_logs();
        for (int g = 0; g < 2; g++) begin
            got[g].delete(); b_port[g].delete(); b_reads[g].delete();
        end
        rd_log.delete();
    endtask

    task automatic do_reset();
        for (int g = 0; g < 2; g++)
            for (int p = 0; p < 4; p++) src_q[g][p].delete();
        rst_req = 1'b1;
        step();
        step();
        rst_req = 1'b0;
        step();
        clear_logs();
    endtask

    task automatic load(int g, int p, int n, int base);
        for (int i = 0; i < n; i++) src_q[g][p].push_back(16'(base + i));
        if (n > 0) f_empty[g][p] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nexp [4];
        reset = 1'b1;
        output_ready = 1'b1;
        for (int g = 0; g < 2; g++) begin
            f_empty[g] = 4'hF; f_valid[g] = '0; f_data[g] = '0;
            model_reset(g); prev_ga[g] = 0;
        end

        // Reset state
        do_reset();
        sample();
        for (int g = 0; g < 2; g++) begin
            check("rst_output_valid", o_valid[g], 0);
            check("rst_output_data", o_data[g], 0);
            check("rst_output_port", o_port[g], 0);
            check("rst_grant_active", ga[g], 0);
            check("rst_grant_port", gp[g], 0);
            check("rst_read_enable", f_rd[g], 0);
        end
        advance();

        // Single port 2 with three words
        do_reset();
        load(0, 2, 3, 16'h2200);
        for (int i = 0; i < 50 && got[0].size() < 3; i++) step();
        repeat (3) step();
        check("p2_read_count", rd_log.size(), 3);
        if (rd_log.size() == 3) check("p2_reads_consecutive", rd_log[2] - rd_log[0], 2);
        check("p2_word_count", got[0].size(), 3);
        for (int i = 0; i < 3 && i < got[0].size(); i++) begin
            check("p2_word", got[0][i].d, 16'h2200 + i);
            check("p2_tag", got[0][i].p, 2);
        end
        sample();
        check("p2_back_to_idle", ga[0], 0);
        advance();

        // All four ports loaded: round robin with full bursts
        do_reset();
        for (int p = 0; p < 4; p++) load(0, p, 20, p * 256);
        for (int i = 0; i < 600 && got[0].size() < 80; i++) step();
        check("rr_total_words", got[0].size(), 80);
        check("rr_burst_log_len", b_port[0].size() >= 5, 1);
        for (int i = 0; i < 5 && i < b_port[0].size(); i++) begin
            check("rr_grant_port", b_port[0][i], i % 4);
            check("rr_burst_reads", b_reads[0][i], 8);
        end

        // Downstream stalled: credit limits outstanding reads to four
        rdy_req = 1'b0;
        do_reset();
        load(0, 0, 10, 16'h0A00);
        repeat (20) step();
        sample();
        check("stall_reads_issued", b_reads[0].size() == 1 ? b_reads[0][0] : -1, 4);
        check("stall_read_enable", f_rd[0], 0);
        check("stall_output_valid", o_valid[0], 1);
        check("stall_keeps_grant", ga[0], 1);
        rdy_req = 1'b1;
        advance();
        for (int i = 0; i < 200 && got[0].size() < 10; i++) step();
        check("stall_word_count", got[0].size(), 10);
        for (int i = 0; i < 10 && i < got[0].size(); i++) begin
            check("stall_word", got[0][i].d, 16'h0A00 + i);
            check("stall_tag", got[0][i].p, 0);
        end

        // Port 1 empties mid-burst, port 2 follows
        do_reset();
        load(0, 1, 3, 16'h1100);
        load(0, 2, 5, 16'h1200);
        for (int i = 0; i < 200 && got[0].size() < 8; i++) step();
        check("empty_burst_count", b_port[0].size(), 2);
        if (b_port[0].size() >= 2) begin
            check("empty_first_port", b_port[0][0], 1);
            check("empty_first_reads", b_reads[0][0], 3);
            check("empty_next_port", b_port[0][1], 2);
            check("empty_next_reads", b_reads[0][1], 5);
        end

        // One-cycle reset during a burst on port 3
        do_reset();
        load(0, 3, 10, 16'h3300);
        repeat (3) step();
        sample();
        check("pulse_pre_grant_active", ga[0], 1);
        check("pulse_pre_grant_port", gp[0], 3);
        advance();
        load(0, 0, 4, 16'h0500);
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        clear_logs();
        sample();
        check("pulse_read_enable", f_rd[0], 0);
        check("pulse_output_valid", o_valid[0], 0);
        check("pulse_grant_active", ga[0], 0);
        advance();
        for (int i = 0; i < 300 && (src_q[0][0].size() + src_q[0][3].size() != 0 || m_buf[0].size() != 0); i++) step();
        check("pulse_next_grant", b_port[0].size() != 0 ? b_port[0][0] : -1, 0);
        check("pulse_drained", src_q[0][0].size() + src_q[0][3].size() + m_buf[0].size(), 0);

        // READ_LATENCY=2 instance, random backpressure, 1000 words
        do_reset();
        for (int p = 0; p < 4; p++) load(1, p, 250, p << 12);
        for (int i = 0; i < 20000 && got[1].size() < 1000; i++) begin
            rdy_req = 1'($urandom_range(0, 1));
            step();
        end
        rdy_req = 1'b1;
        check("lat2_total_words", got[1].size(), 1000);
        for (int p = 0; p < 4; p++) nexp[p] = 0;
        foreach (got[1][i]) begin
            check("lat2_port_order", got[1][i].d, (got[1][i].p << 12) | nexp[got[1][i].p]);
            nexp[got[1][i].p]++;
        end
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
